// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies debounced press/release pulses into short, double, long,
// auto-repeat and long-release one-cycle events using a single shared cycle counter.
module button_event_decoder #(
    parameter int              CNT_W         = 24,
    parameter logic [CNT_W-1:0] LONG_CYCLES   = 24'd6000000,
    parameter logic [CNT_W-1:0] GAP_CYCLES    = 24'd3000000,
    parameter logic [CNT_W-1:0] REPEAT_CYCLES = 24'd1200000
) (
    input  logic clk,
    input  logic rst,
    input  logic button_db,
    input  logic button_rising,
    input  logic button_falling,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic long_release,
    output logic held,
    output logic busy
);
    typedef enum logic [2:0] {IDLE, PRESS1, GAP, PRESS2, LONG_HELD} state_t;

    localparam logic [CNT_W-1:0] LONG_T = LONG_CYCLES - 1'b1;
    localparam logic [CNT_W-1:0] GAP_T  = GAP_CYCLES - 1'b1;
    localparam logic [CNT_W-1:0] REP_T  = REPEAT_CYCLES - 1'b1;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [4:0]       ev_n;
    logic             rise, fall;

    // a simultaneous rising pulse is dropped in favour of the release
    assign rise = button_rising & ~button_falling;
    assign fall = button_falling;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            {long_release, repeat_pulse, long_press, double_press, short_press} <= '0;
            held  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            {long_release, repeat_pulse, long_press, double_press, short_press} <= ev_n;
            held  <= button_db;
            busy  <= state_n != IDLE;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                state_n = rise ? PRESS1 : IDLE;
                cnt_n   = '0;
            end
            PRESS1: begin
                state_n = fall ? GAP : (cnt == LONG_T) ? LONG_HELD : PRESS1;
                cnt_n   = (fall || cnt == LONG_T) ? '0 : cnt + 1'b1;
            end
            GAP: begin
                state_n = rise ? PRESS2 : (cnt == GAP_T) ? IDLE : GAP;
                cnt_n   = (rise || cnt == GAP_T) ? '0 : cnt + 1'b1;
            end
            PRESS2: begin
                state_n = fall ? IDLE : PRESS2;
                cnt_n   = '0;
            end
            LONG_HELD: begin
                state_n = fall ? IDLE : LONG_HELD;
                cnt_n   = (fall || cnt == REP_T) ? '0 : cnt + 1'b1;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_comb begin
        ev_n    = '0;
        ev_n[0] = state == GAP && !rise && cnt == GAP_T;
        ev_n[1] = state == PRESS2 && fall;
        ev_n[2] = state == PRESS1 && !fall && cnt == LONG_T;
        ev_n[3] = state == LONG_HELD && !fall && cnt == REP_T;
        ev_n[4] = state == LONG_HELD && fall;
    end
endmodule
